// File: rtl/axi_ad9364_pkg.sv
// Shared AD9364 definitions: checker FSM encodings and the default A/B loopback
// pattern words that the Tx data generator also uses.
package axi_ad9364_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_LOCKING = 2'd2,
        ST_LOCKED  = 2'd3
    } chk_state_e;

    localparam logic [11:0] PAT_IDATA_A = 12'o2064;
    localparam logic [11:0] PAT_QDATA_A = 12'o1753;
    localparam logic [11:0] PAT_IDATA_B = 12'o4402;
    localparam logic [11:0] PAT_QDATA_B = 12'o1337;

    typedef struct packed {
        logic [11:0] i;
        logic [11:0] q;
    } iq_word_t;

    function automatic logic iq_match(input iq_word_t a, input iq_word_t b);
        return (a == b);
    endfunction

endpackage

// File: rtl/axi_ad9364_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module axi_ad9364_sat_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {CNT_WIDTH{1'b1}})) begin
            q <= q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/axi_ad9364_rx_pattern_chk.sv
// Rx loopback checker for the alternating A/B pattern in 1R1T mode.
// Optional sticky error flag is built only when ADC_CHK_STICKY_EN is defined.
module axi_ad9364_rx_pattern_chk
    import axi_ad9364_pkg::*;
#(
    parameter logic [11:0] IDATA_A    = PAT_IDATA_A,
    parameter logic [11:0] QDATA_A    = PAT_QDATA_A,
    parameter logic [11:0] IDATA_B    = PAT_IDATA_B,
    parameter logic [11:0] QDATA_B    = PAT_QDATA_B,
    parameter int          LOCK_COUNT = 16,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 adc_valid,
    input  logic [11:0]          adc_data_i1,
    input  logic [11:0]          adc_data_q1,
    input  logic                 adc_r1_mode,
    input  logic                 chk_clear,
    output logic                 chk_locked,
    output logic                 chk_oos,
    output logic [CNT_WIDTH-1:0] chk_err_count,
    output logic [CNT_WIDTH-1:0] chk_sample_count,
    output logic [23:0]          chk_last_bad,
    output logic                 chk_err_sticky
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [GW-1:0] GOOD_ONE  = GW'(1);

    chk_state_e    state_q;
    logic [GW-1:0] good_cnt_q;
    logic          phase_q;
    logic          miss_q;
    logic          oos_q;
    logic [23:0]   last_bad_q;

    iq_word_t rx_word;
    logic     word_a, word_b, match;
    logic     smp_inc, err_inc;

    always_comb begin
        rx_word = '{i: adc_data_i1, q: adc_data_q1};
        word_a  = iq_match(rx_word, '{i: IDATA_A, q: QDATA_A});
        word_b  = iq_match(rx_word, '{i: IDATA_B, q: QDATA_B});
        match   = phase_q ? word_b : word_a;
        smp_inc = adc_r1_mode && adc_valid && (state_q == ST_LOCKED);
        err_inc = smp_inc && !match;
    end

    // Leaving 1R1T mode overrides everything and parks the FSM in IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            good_cnt_q <= '0;
            phase_q    <= 1'b0;
            miss_q     <= 1'b0;
            oos_q      <= 1'b0;
        end else begin
            oos_q <= 1'b0;
            if (!adc_r1_mode) begin
                state_q    <= ST_IDLE;
                good_cnt_q <= '0;
                phase_q    <= 1'b0;
                miss_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_SEARCH;
                    ST_SEARCH: begin
                        if (adc_valid && (word_a || word_b)) begin
                            phase_q    <= word_a;
                            good_cnt_q <= GOOD_ONE;
                            state_q    <= ST_LOCKING;
                        end
                    end
                    ST_LOCKING: begin
                        if (adc_valid) begin
                            if (match) begin
                                phase_q    <= ~phase_q;
                                good_cnt_q <= good_cnt_q + GOOD_ONE;
                                if (good_cnt_q == GOOD_LAST) state_q <= ST_LOCKED;
                            end else begin
                                good_cnt_q <= '0;
                                state_q    <= ST_SEARCH;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (adc_valid) begin
                            phase_q <= ~phase_q;
                            if (match) begin
                                miss_q <= 1'b0;
                            end else if (miss_q) begin
                                // Two misses in a row: the stream slipped, so re-acquire.
                                miss_q     <= 1'b0;
                                good_cnt_q <= '0;
                                oos_q      <= 1'b1;
                                state_q    <= ST_SEARCH;
                            end else begin
                                miss_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_bad_q <= '0;
        end else if (chk_clear) begin
            last_bad_q <= '0;
        end else if (err_inc) begin
            last_bad_q <= rx_word;
        end
    end

    axi_ad9364_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (err_inc),
        .clr  (chk_clear),
        .q    (chk_err_count)
    );

    axi_ad9364_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_smp_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (smp_inc),
        .clr  (chk_clear),
        .q    (chk_sample_count)
    );

`ifdef ADC_CHK_STICKY_EN
    logic sticky_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sticky_q <= 1'b0;
        end else if (chk_clear) begin
            sticky_q <= 1'b0;
        end else if (err_inc || oos_q) begin
            sticky_q <= 1'b1;
        end
    end

    assign chk_err_sticky = sticky_q;
`else
    assign chk_err_sticky = 1'b0;
`endif

    assign chk_locked   = (state_q == ST_LOCKED);
    assign chk_oos      = oos_q;
    assign chk_last_bad = last_bad_q;

endmodule

// File: tb/tb_axi_ad9364_rx_pattern_chk.sv
// Directed bench for the A/B loopback checker; a behavioural model is compared every cycle.
module tb_axi_ad9364_rx_pattern_chk;

    localparam int CW   = 6;
    localparam int LOCK = 16;
    localparam int MAXC = (1 << CW) - 1;
    localparam logic [11:0] IA = 12'o2064, QA = 12'o1753;
    localparam logic [11:0] IB = 12'o4402, QB = 12'o1337;
`ifdef ADC_CHK_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          adc_valid;
    logic [11:0]   adc_data_i1, adc_data_q1;
    logic          adc_r1_mode, chk_clear;
    logic          chk_locked, chk_oos, chk_err_sticky;
    logic [CW-1:0] chk_err_count, chk_sample_count;
    logic [23:0]   chk_last_bad;

    axi_ad9364_rx_pattern_chk #(.LOCK_COUNT(LOCK), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .adc_valid        (adc_valid),
        .adc_data_i1      (adc_data_i1),
        .adc_data_q1      (adc_data_q1),
        .adc_r1_mode      (adc_r1_mode),
        .chk_clear        (chk_clear),
        .chk_locked       (chk_locked),
        .chk_oos          (chk_oos),
        .chk_err_count    (chk_err_count),
        .chk_sample_count (chk_sample_count),
        .chk_last_bad     (chk_last_bad),
        .chk_err_sticky   (chk_err_sticky)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: acquisition is a run length of good words; lock is a flag once the run hits LOCK.
    bit        m_active, m_locked, m_expect_b, m_miss, m_oos, m_sticky;
    int        m_run, m_err, m_smp;
    logic [23:0] m_last;

    task automatic model_reset();
        m_active = 0; m_locked = 0; m_expect_b = 0; m_miss = 0; m_oos = 0; m_sticky = 0;
        m_run = 0; m_err = 0; m_smp = 0; m_last = '0;
    endtask

    task automatic model_step(input bit v, input logic [23:0] w, input bit mode, input bit clr);
        bit is_a, is_b, good;
        is_a = (w == {IA, QA});
        is_b = (w == {IB, QB});
        good = m_expect_b ? is_b : is_a;
        if (STICKY && m_oos) m_sticky = 1;
        m_oos = 0;
        if (!mode) begin
            m_active = 0; m_locked = 0; m_run = 0; m_miss = 0;
        end else if (!m_active) begin
            m_active = 1;
        end else if (v) begin
            if (m_locked) begin
                if (m_smp < MAXC) m_smp++;
                if (!good) begin
                    if (m_err < MAXC) m_err++;
                    m_last = w;
                    if (STICKY) m_sticky = 1;
                    if (m_miss) begin
                        m_locked = 0; m_run = 0; m_miss = 0; m_oos = 1;
                    end else m_miss = 1;
                end else m_miss = 0;
                m_expect_b = !m_expect_b;
            end else if (m_run == 0) begin
                if (is_a || is_b) begin
                    m_expect_b = is_a;
                    m_run = 1;
                end
            end else if (good) begin
                m_expect_b = !m_expect_b;
                m_run++;
                if (m_run == LOCK) m_locked = 1;
            end else m_run = 0;
        end
        if (clr) begin
            m_err = 0; m_smp = 0; m_last = '0; m_sticky = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) model_reset();
            else model_step(adc_valid, {adc_data_i1, adc_data_q1}, adc_r1_mode, chk_clear);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("locked", chk_locked, m_locked);
            check("oos", chk_oos, m_oos);
            check("err_count", chk_err_count, m_err);
            check("sample_count", chk_sample_count, m_smp);
            check("last_bad", chk_last_bad, m_last);
            check("sticky", chk_err_sticky, m_sticky);
        end
    end

    // Stimulus: inputs change 1 time unit after the rising edge.
    bit nxt_b = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] i, input logic [11:0] q, input int gap);
        adc_valid = 1; adc_data_i1 = i; adc_data_q1 = q;
        tick();
        adc_valid = 0;
        repeat (gap) tick();
        nxt_b = !nxt_b;
    endtask

    task automatic send_good(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            if (nxt_b) send(IB, QB, gap);
            else send(IA, QA, gap);
        end
    endtask

    initial begin
        rstn = 0; adc_valid = 0; adc_data_i1 = '0; adc_data_q1 = '0;
        adc_r1_mode = 0; chk_clear = 0;
        repeat (3) tick();
        check("rst_locked", chk_locked, 0);
        check("rst_err", chk_err_count, 0);
        check("rst_last_bad", chk_last_bad, 0);
        rstn = 1; adc_r1_mode = 1;
        tick();

        // Back-to-back pattern: lock on the 16th word, then count 4.
        send_good(LOCK - 1, 0);
        check("s1_not_yet_locked", chk_locked, 0);
        send_good(1, 0);
        check("s1_locked", chk_locked, 1);
        send_good(4, 0);
        check("s1_sample_count", chk_sample_count, 4);
        check("s1_err_count", chk_err_count, 0);

        // Single zero word while locked.
        send(12'o0000, 12'o0000, 0);
        check("s2_err", chk_err_count, 1);
        check("s2_last_bad", chk_last_bad, 0);
        check("s2_locked", chk_locked, 1);
        send_good(1, 0);
        check("s2_err_hold", chk_err_count, 1);
        check("s2_smp", chk_sample_count, 6);

        // Two bad words in a row lose lock.
        send(12'o7777, 12'o0001, 0);
        check("s3_last_bad1", chk_last_bad, 24'o7777_0001);
        send(12'o1234, 12'o4321, 0);
        check("s3_oos", chk_oos, 1);
        check("s3_unlocked", chk_locked, 0);
        check("s3_err", chk_err_count, 3);
        check("s3_last_bad2", chk_last_bad, 24'o1234_4321);
        tick();
        check("s3_oos_pulse", chk_oos, 0);
        check("s3_sticky", chk_err_sticky, STICKY);
        send_good(LOCK, 0);
        check("s3_relock", chk_locked, 1);

        // Clear, leave and re-enter 1R1T, then gapped stream.
        chk_clear = 1; tick(); chk_clear = 0;
        check("s4_clear_err", chk_err_count, 0);
        check("s4_clear_sticky", chk_err_sticky, 0);
        adc_r1_mode = 0; tick();
        check("s4_mode_off", chk_locked, 0);
        adc_r1_mode = 1; tick();
        send_good(LOCK - 1, 1);
        check("s4_not_yet_locked", chk_locked, 0);
        send_good(1, 1);
        check("s4_locked", chk_locked, 1);
        send_good(4, 1);
        check("s4_sample_count", chk_sample_count, 4);
        check("s4_err_count", chk_err_count, 0);

        // Saturate both counters, then clear coincident with an error.
        send_good(70, 0);
        check("s5_smp_sat", chk_sample_count, MAXC);
        for (int k = 0; k < MAXC + 2; k++) begin
            send(12'o0707, 12'o0070, 0);
            send_good(1, 0);
        end
        check("s5_err_sat", chk_err_count, MAXC);
        check("s5_still_locked", chk_locked, 1);
        chk_clear = 1;
        send(12'o0555, 12'o0222, 0);
        chk_clear = 0;
        check("s5_clr_err", chk_err_count, 0);
        check("s5_clr_smp", chk_sample_count, 0);
        check("s5_clr_last_bad", chk_last_bad, 0);
        send_good(1, 0);
        check("s5_smp_restart", chk_sample_count, 1);

        // Error then asynchronous reset while locked.
        send(12'o0001, 12'o0002, 0);
        send_good(1, 0);
        check("s6_sticky", chk_err_sticky, STICKY);
        #2 rstn = 0;
        #1;
        check("s6_rst_locked", chk_locked, 0);
        check("s6_rst_err", chk_err_count, 0);
        check("s6_rst_smp", chk_sample_count, 0);
        check("s6_rst_last_bad", chk_last_bad, 0);
        check("s6_rst_sticky", chk_err_sticky, 0);
        repeat (2) tick();
        rstn = 1;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
